vec3_alu_seq: RTL

Sequential, parametrised 3D vector ALU: successor to the combinational 8-bit vector datapath. A single shared signed multiplier is time-multiplexed under an FSM, so cross, dot and magnitude-compare operations complete in a few cycles at a fraction of the area. Operands and results move over valid/ready handshakes, so the block sits directly behind a command queue and in front of a result sink.

---
 rtl/vec3_alu_pkg.sv | 47 ++++
 rtl/vec3_alu_seq_mul.sv | 12 +
 rtl/vec3_alu_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vec3_alu_pkg.sv
// rtl/vec3_alu_pkg.sv - opcodes, FSM states and per-op step counts for vec3_alu_seq
// Build option VEC3_ALU_CMP_EN enables the CMP and ORTHO opcodes.
package vec3_alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_SUB   = 3'd1,
        OP_CROSS = 3'd2,
        OP_SCALE = 3'd3,
        OP_DOT   = 3'd4,
        OP_CMP   = 3'd5,
        OP_ORTHO = 3'd6,
        OP_RSV   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two guard bits above the 2W-bit product keep three-term sums exact.
    function automatic int rw_of(input int w);
        return 2 * w + 2;
    endfunction

    function automatic logic [2:0] step_count(input op_e o);
        case (o)
            OP_CROSS:         return 3'd6;
            OP_SCALE, OP_DOT: return 3'd3;
`ifdef VEC3_ALU_CMP_EN
            OP_CMP:           return 3'd6;
            OP_ORTHO:         return 3'd3;
`endif
            default:          return 3'd1;
        endcase
    endfunction

    function automatic logic op_unsupported(input op_e o);
`ifdef VEC3_ALU_CMP_EN
        return o == OP_RSV;
`else
        return o inside {OP_CMP, OP_ORTHO, OP_RSV};
`endif
    endfunction

endpackage

// File: rtl/vec3_alu_seq_mul.sv
// rtl/vec3_alu_seq_mul.sv - combinational W x W signed multiplier, 2W-bit exact product
module vec3_mul #(
    parameter int W = 8
) (
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    assign p = a * b;

endmodule

// File: rtl/vec3_alu_seq.sv
// rtl/vec3_alu_seq.sv - sequential 3D vector ALU with one shared multiplier
// Build option VEC3_ALU_CMP_EN adds CMP and ORTHO; otherwise ops 5/6 report err like op 7.
module vec3_alu_seq
    import vec3_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    op,
    input  logic [W-1:0]                  ax,
    input  logic [W-1:0]                  ay,
    input  logic [W-1:0]                  az,
    input  logic [W-1:0]                  bx,
    input  logic [W-1:0]                  by,
    input  logic [W-1:0]                  bz,
    input  logic [W-1:0]                  s,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [rw_of(W)-1:0]    res_x,
    output logic signed [rw_of(W)-1:0]    res_y,
    output logic signed [rw_of(W)-1:0]    res_z,
    output logic                          err
);

    localparam int RW = rw_of(W);

    state_e                 state, state_nxt;
    op_e                    op_r;
    logic [2:0][W-1:0]      a_r, b_r;
    logic [W-1:0]           s_r;
    logic [2:0]             step, last_r;
    logic                   last, err_r;
    logic signed [RW-1:0]   acc [3];
    logic signed [RW-1:0]   nxt [3];
    logic signed [W-1:0]    mul_a, mul_b;
    logic signed [2*W-1:0]  prod;
    logic signed [RW-1:0]   prod_ext, sum;
`ifdef VEC3_ALU_CMP_EN
    logic signed [RW-1:0]   diff;
    logic [2:0]             step_m3;
`endif

    function automatic logic signed [RW-1:0] sx(input logic [W-1:0] v);
        return {{(RW-W){v[W-1]}}, v};
    endfunction

    vec3_mul #(.W(W)) u_mul (.a(mul_a), .b(mul_b), .p(prod));

    assign prod_ext  = {{(RW-2*W){prod[2*W-1]}}, prod};
    assign last      = (step == last_r);
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign res_x     = acc[0];
    assign res_y     = acc[1];
    assign res_z     = acc[2];
    assign err       = err_r;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_EXEC;
            ST_EXEC: if (last)      state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Multiplier operand select: which pair of components this step consumes.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
`ifdef VEC3_ALU_CMP_EN
        step_m3 = step - 3'd3;
`endif
        case (op_r)
            OP_SCALE: begin
                mul_a = s_r;
                mul_b = a_r[step[1:0]];
            end
            OP_DOT: begin
                mul_a = a_r[step[1:0]];
                mul_b = b_r[step[1:0]];
            end
            OP_CROSS: begin
                case (step)
                    3'd0:    begin mul_a = a_r[1]; mul_b = b_r[2]; end
                    3'd1:    begin mul_a = a_r[2]; mul_b = b_r[1]; end
                    3'd2:    begin mul_a = a_r[2]; mul_b = b_r[0]; end
                    3'd3:    begin mul_a = a_r[0]; mul_b = b_r[2]; end
                    3'd4:    begin mul_a = a_r[0]; mul_b = b_r[1]; end
                    default: begin mul_a = a_r[1]; mul_b = b_r[0]; end
                endcase
            end
`ifdef VEC3_ALU_CMP_EN
            OP_ORTHO: begin
                mul_a = a_r[step[1:0]];
                mul_b = b_r[step[1:0]];
            end
            OP_CMP: begin
                if (step < 3'd3) begin
                    mul_a = a_r[step[1:0]];
                    mul_b = a_r[step[1:0]];
                end else begin
                    mul_a = b_r[step_m3[1:0]];
                    mul_b = b_r[step_m3[1:0]];
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) nxt[i] = acc[i];
        sum = acc[0] + prod_ext;
`ifdef VEC3_ALU_CMP_EN
        diff = acc[0] - prod_ext;
`endif
        case (op_r)
            OP_ADD:   for (int i = 0; i < 3; i++) nxt[i] = sx(a_r[i]) + sx(b_r[i]);
            OP_SUB:   for (int i = 0; i < 3; i++) nxt[i] = sx(a_r[i]) - sx(b_r[i]);
            OP_SCALE: nxt[step[1:0]] = prod_ext;
            OP_DOT:   nxt[0] = sum;
            // Even steps add the positive cross term, odd steps subtract the negative one.
            OP_CROSS: nxt[step[2:1]] = step[0] ? acc[step[2:1]] - prod_ext
                                               : acc[step[2:1]] + prod_ext;
`ifdef VEC3_ALU_CMP_EN
            OP_ORTHO: nxt[0] = last ? ((sum == '0) ? RW'(1) : '0) : sum;
            OP_CMP: begin
                if (step < 3'd3)  nxt[0] = sum;
                else if (!last)   nxt[0] = diff;
                else if (diff == '0) nxt[0] = '0;
                else              nxt[0] = diff[RW-1] ? RW'(2) : RW'(1);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_r   <= OP_ADD;
            a_r    <= '0;
            b_r    <= '0;
            s_r    <= '0;
            step   <= '0;
            last_r <= '0;
            err_r  <= 1'b0;
            for (int i = 0; i < 3; i++) acc[i] <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && in_valid) begin
                op_r   <= op_e'(op);
                a_r    <= {az, ay, ax};
                b_r    <= {bz, by, bx};
                s_r    <= s;
                step   <= '0;
                last_r <= step_count(op_e'(op)) - 3'd1;
                err_r  <= op_unsupported(op_e'(op));
                for (int i = 0; i < 3; i++) acc[i] <= '0;
            end else if (state == ST_EXEC) begin
                step <= step + 3'd1;
                for (int i = 0; i < 3; i++) acc[i] <= nxt[i];
            end
        end
    end

endmodule
